// File: rtl/text_blit_ctrl.sv
// Text Table (TXBL) write-port sequencer and arbiter.
// Runs FILL (range fill) and SCROLL (copy rows up, clear bottom row) commands
// one write per cycle; any CPU write to TXBL takes the port and stalls the engine.
// Optional feature macro: TEXT_BLIT_IRQ_EN adds a sticky completion interrupt
// (irq_o / irq_clr_i).
module text_blit_ctrl #(
  parameter int unsigned ROWS    = 30,
  parameter int unsigned COLS    = 32,
  parameter int unsigned TXBL_AW = 10
) (
  input  logic               cpu_clk,
  input  logic               rst_n,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [1:0]         cmd_op_i,
  input  logic [7:0]         cmd_tile_i,
  input  logic [TXBL_AW-1:0] cmd_start_i,
  input  logic [TXBL_AW:0]   cmd_count_i,
  input  logic               cpu_wen_i,
  input  logic [TXBL_AW-1:0] cpu_addr_i,
  input  logic [7:0]         cpu_wdata_i,
  output logic [TXBL_AW-1:0] eng_raddr_o,
  input  logic [7:0]         eng_rdata_i,
  output logic               txbl_wen_o,
  output logic [TXBL_AW-1:0] txbl_waddr_o,
  output logic [7:0]         txbl_wdata_o,
  output logic               busy_o,
  output logic               done_o
`ifdef TEXT_BLIT_IRQ_EN
  ,
  output logic               irq_o,
  input  logic               irq_clr_i
`endif
);

  localparam logic [1:0] OpFill   = 2'b01;
  localparam logic [1:0] OpScroll = 2'b10;

  localparam logic [TXBL_AW-1:0] AddrOne   = TXBL_AW'(1);
  localparam logic [TXBL_AW-1:0] ColStride = TXBL_AW'(COLS);
  // Last destination of the row copy and last entry of the cleared bottom row.
  localparam logic [TXBL_AW-1:0] CopyLast  = TXBL_AW'((ROWS - 1) * COLS - 1);
  localparam logic [TXBL_AW-1:0] ClearLast = TXBL_AW'(ROWS * COLS - 1);
  localparam logic [TXBL_AW:0]   RemOne    = (TXBL_AW + 1)'(1);

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StCopy,
    StClear,
    StDone
  } state_e;

  state_e               state_q, state_d;
  logic [TXBL_AW-1:0]   addr_q, addr_d;
  logic [TXBL_AW:0]     rem_q, rem_d;
  logic [7:0]           tile_q, tile_d;
  logic                 eng_we;
  logic [7:0]           eng_wdata;

  // State and command registers; reset aborts any command in flight.
  always_ff @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rem_q   <= '0;
      tile_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      tile_q  <= tile_d;
    end
  end

  // Next-state logic; a CPU write this cycle freezes address and counter.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    tile_d      = tile_q;
    eng_we      = 1'b0;
    eng_wdata   = tile_q;
    cmd_ready_o = 1'b0;
    done_o      = 1'b0;
    unique case (state_q)
      StIdle: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          tile_d = cmd_tile_i;
          addr_d = cmd_start_i;
          rem_d  = cmd_count_i;
          if (cmd_op_i == OpFill) begin
            state_d = (cmd_count_i != '0) ? StFill : StDone;
          end else if (cmd_op_i == OpScroll) begin
            addr_d  = '0;
            state_d = StCopy;
          end else begin
            state_d = StDone;
          end
        end
      end
      StFill: begin
        eng_we = 1'b1;
        if (!cpu_wen_i) begin
          addr_d = addr_q + AddrOne;
          rem_d  = rem_q - RemOne;
          if (rem_q == RemOne) state_d = StDone;
        end
      end
      StCopy: begin
        eng_we    = 1'b1;
        eng_wdata = eng_rdata_i;
        if (!cpu_wen_i) begin
          // Clear row begins right after the copy region, so the address just runs on.
          addr_d = addr_q + AddrOne;
          if (addr_q == CopyLast) state_d = StClear;
        end
      end
      StClear: begin
        eng_we = 1'b1;
        if (!cpu_wen_i) begin
          addr_d = addr_q + AddrOne;
          if (addr_q == ClearLast) state_d = StDone;
        end
      end
      StDone: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Write-port mux: CPU has absolute priority over the engine.
  always_comb begin
    txbl_wen_o   = cpu_wen_i | eng_we;
    txbl_waddr_o = cpu_wen_i ? cpu_addr_i  : addr_q;
    txbl_wdata_o = cpu_wen_i ? cpu_wdata_i : eng_wdata;
    eng_raddr_o  = (state_q == StCopy) ? (addr_q + ColStride) : '0;
    busy_o       = (state_q != StIdle);
  end

`ifdef TEXT_BLIT_IRQ_EN
  logic irq_q;

  // Sticky completion flag; a set in the same cycle as a clear wins.
  always_ff @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q <= 1'b0;
    end else if (done_o) begin
      irq_q <= 1'b1;
    end else if (irq_clr_i) begin
      irq_q <= 1'b0;
    end
  end

  // Raised in the done cycle itself, not one cycle later.
  always_comb begin
    irq_o = irq_q | done_o;
  end
`endif

endmodule

// File: tb/tb_text_blit_ctrl.sv
// Self-checking bench for text_blit_ctrl: TXBL memory model, directed and
// randomized FILL/SCROLL commands with random CPU stalls, mid-command reset.
module tb_text_blit_ctrl;

  localparam int ROWS = 30;
  localparam int COLS = 32;
  localparam int AW   = 10;
  localparam int MAXC = 4096;

  logic          cpu_clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [7:0]    cmd_tile;
  logic [AW-1:0] cmd_start;
  logic [AW:0]   cmd_count;
  logic          cpu_wen;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata;
  logic [AW-1:0] eng_raddr;
  logic [7:0]    eng_rdata;
  logic          txbl_wen;
  logic [AW-1:0] txbl_waddr;
  logic [7:0]    txbl_wdata;
  logic          busy;
  logic          done;
`ifdef TEXT_BLIT_IRQ_EN
  logic          irq;
  logic          irq_clr;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0]    mem [1024];   // TXBL storage driven by the DUT write port
  logic [7:0]    mdl [1024];   // expected TXBL contents
  logic [AW-1:0] eng_log [$];  // addresses of engine (non-CPU) writes
  bit            pat_wen  [MAXC];
  logic [AW-1:0] pat_addr [MAXC];
  logic [7:0]    pat_data [MAXC];

  text_blit_ctrl #(.ROWS(ROWS), .COLS(COLS), .TXBL_AW(AW)) dut (
    .cpu_clk      (cpu_clk),
    .rst_n        (rst_n),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_op_i     (cmd_op),
    .cmd_tile_i   (cmd_tile),
    .cmd_start_i  (cmd_start),
    .cmd_count_i  (cmd_count),
    .cpu_wen_i    (cpu_wen),
    .cpu_addr_i   (cpu_addr),
    .cpu_wdata_i  (cpu_wdata),
    .eng_raddr_o  (eng_raddr),
    .eng_rdata_i  (eng_rdata),
    .txbl_wen_o   (txbl_wen),
    .txbl_waddr_o (txbl_waddr),
    .txbl_wdata_o (txbl_wdata),
    .busy_o       (busy),
    .done_o       (done)
`ifdef TEXT_BLIT_IRQ_EN
    ,
    .irq_o        (irq),
    .irq_clr_i    (irq_clr)
`endif
  );

  initial begin
    cpu_clk = 1'b0;
    forever #5 cpu_clk = ~cpu_clk;
  end

  assign eng_rdata = mem[eng_raddr];

  // TXBL array plus a log of engine-originated write addresses.
  always @(posedge cpu_clk) begin
    if (txbl_wen) begin
      mem[txbl_waddr] <= txbl_wdata;
      if (!cpu_wen) eng_log.push_back(txbl_waddr);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One command end to end: builds a CPU stall pattern on addresses the engine
  // never touches, predicts completion cycle and final TXBL, then compares.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] tile, input logic [AW-1:0] start,
                         input int count, input int stall_pct, input int c0, input int c1,
                         input string tag);
    int n, d, w, done_at, pulses, mis;
    logic [7:0] old [1024];
    logic [AW-1:0] exp_addr [$];
    logic r_d, b_d, r_d1, b_d1;
    n = (op == 2'b01) ? count : (op == 2'b10) ? ROWS * COLS : 0;
    for (int k = 0; k < MAXC; k++) begin
      pat_wen[k]  = (k > 0) && ($urandom_range(99) < stall_pct);
      pat_data[k] = 8'($urandom);
      if (op == 2'b10) pat_addr[k] = AW'(ROWS * COLS + $urandom_range(1023 - ROWS * COLS));
      else if (op == 2'b01 && count < 1024)
        pat_addr[k] = AW'((int'(start) + count + $urandom_range(1023 - count)) % 1024);
      else begin
        pat_addr[k] = AW'($urandom);
        if (op == 2'b01) pat_wen[k] = 1'b0;
      end
      if (k == c0 || k == c1) begin
        pat_wen[k]  = 1'b1;
        pat_addr[k] = 10'h200;
      end
    end
    // Completion cycle: one write per cycle without a CPU write.
    d = 1;
    w = 0;
    while (w < n && d < MAXC - 3) begin
      if (!pat_wen[d]) w++;
      d++;
    end
    for (int k = d; k < MAXC; k++) pat_wen[k] = 1'b0;
    old = mdl;
    if (op == 2'b01) begin
      for (int i = 0; i < n; i++) begin
        exp_addr.push_back(AW'((int'(start) + i) % 1024));
        mdl[(int'(start) + i) % 1024] = tile;
      end
    end else if (op == 2'b10) begin
      for (int a = 0; a < ROWS * COLS; a++) begin
        exp_addr.push_back(AW'(a));
        mdl[a] = (a < (ROWS - 1) * COLS) ? old[a + COLS] : tile;
      end
    end
    for (int k = 1; k < d; k++) if (pat_wen[k]) mdl[pat_addr[k]] = pat_data[k];

    @(negedge cpu_clk);
    check({tag, "/ready_pre"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_tile  = tile;
    cmd_start = start;
    cmd_count = (AW + 1)'(count);
    cpu_wen   = 1'b0;
    eng_log.delete();
    @(negedge cpu_clk);
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    done_at   = -1;
    pulses    = 0;
    r_d = 1'bx; b_d = 1'bx; r_d1 = 1'bx; b_d1 = 1'bx;
    for (int k = 1; k <= d + 1; k++) begin
      if (done) begin
        pulses++;
        if (done_at < 0) done_at = k;
      end
      if (k == d) begin r_d = cmd_ready; b_d = busy; end
      if (k == d + 1) begin r_d1 = cmd_ready; b_d1 = busy; end
      cpu_wen   = pat_wen[k];
      cpu_addr  = pat_addr[k];
      cpu_wdata = pat_data[k];
      @(negedge cpu_clk);
    end
    cpu_wen = 1'b0;
    check({tag, "/done_cycle"}, 32'(done_at), 32'(d));
    check({tag, "/done_pulses"}, 32'(pulses), 32'd1);
    check({tag, "/ready_in_done"}, 32'(r_d), 32'd0);
    check({tag, "/busy_in_done"}, 32'(b_d), 32'd1);
    check({tag, "/ready_after"}, 32'(r_d1), 32'd1);
    check({tag, "/busy_after"}, 32'(b_d1), 32'd0);
    check({tag, "/eng_writes"}, 32'(eng_log.size()), 32'(n));
    mis = 0;
    for (int i = 0; i < n && i < eng_log.size(); i++) if (eng_log[i] !== exp_addr[i]) mis++;
    check({tag, "/eng_addr_seq"}, 32'(mis), 32'd0);
    mis = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== mdl[i]) mis++;
    check({tag, "/txbl_contents"}, 32'(mis), 32'd0);
  endtask

  initial begin
    logic [7:0] old [1024];
    int mis;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_tile  = 8'h00;
    cmd_start = '0;
    cmd_count = '0;
    cpu_wen   = 1'b1;
    cpu_addr  = 10'h155;
    cpu_wdata = 8'h3C;
`ifdef TEXT_BLIT_IRQ_EN
    irq_clr   = 1'b0;
`endif
    #2;
    check("rst/ready", 32'(cmd_ready), 32'd1);
    check("rst/busy", 32'(busy), 32'd0);
    check("rst/done", 32'(done), 32'd0);
    check("rst/eng_raddr", 32'(eng_raddr), 32'd0);
    check("rst/cpu_wen_pass", 32'(txbl_wen), 32'd1);
    check("rst/cpu_addr_pass", 32'(txbl_waddr), 32'h155);
    check("rst/cpu_data_pass", 32'(txbl_wdata), 32'h3C);
`ifdef TEXT_BLIT_IRQ_EN
    check("rst/irq", 32'(irq), 32'd0);
`endif
    cpu_wen = 1'b0;
    #1;
    check("rst/no_wen", 32'(txbl_wen), 32'd0);
    repeat (2) @(negedge cpu_clk);
    rst_n = 1'b1;

    // Preload TXBL[i] = i[7:0] through the CPU path.
    for (int i = 0; i < 1024; i++) begin
      @(negedge cpu_clk);
      cpu_wen   = 1'b1;
      cpu_addr  = AW'(i);
      cpu_wdata = 8'(i);
      mdl[i]    = 8'(i);
    end
    @(negedge cpu_clk);
    cpu_wen = 1'b0;

    run_cmd(2'b01, 8'h85, 10'h3FE, 4, 0, -1, -1, "fill_wrap");
    run_cmd(2'b10, 8'h00, 10'h000, 0, 0, -1, -1, "scroll");
    run_cmd(2'b01, 8'h4D, 10'h100, 8, 0, 3, 4, "fill_cpu_stall");
    run_cmd(2'b01, 8'hEE, 10'h010, 0, 0, -1, -1, "fill_zero");
    run_cmd(2'b11, 8'hEE, 10'h010, 5, 0, -1, -1, "op_reserved");
    run_cmd(2'b00, 8'hEE, 10'h010, 5, 0, -1, -1, "op_nop");
    run_cmd(2'b01, 8'h5A, 10'h3FF, 1024, 25, -1, -1, "fill_all");
    run_cmd(2'b01, 8'hC3, 10'h2F0, 1, 25, -1, -1, "fill_one");
    for (int t = 0; t < 4; t++)
      run_cmd(2'b01, 8'($urandom), AW'($urandom), int'($urandom_range(1023)), 25, -1, -1,
              $sformatf("fill_rand%0d", t));
    run_cmd(2'b10, 8'($urandom), 10'h000, 0, 20, -1, -1, "scroll_rand");

    // Reset in the middle of a SCROLL: partial copy stays, no done pulse.
    @(negedge cpu_clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_tile  = 8'h77;
    eng_log.delete();
    @(negedge cpu_clk);
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    mis = 0;
    for (int k = 1; k < 100; k++) begin
      if (done) mis++;
      @(negedge cpu_clk);
    end
    rst_n = 1'b0;
    #1;
    check("abort/ready", 32'(cmd_ready), 32'd1);
    check("abort/busy", 32'(busy), 32'd0);
    check("abort/eng_raddr", 32'(eng_raddr), 32'd0);
    repeat (3) begin
      if (done) mis++;
      @(negedge cpu_clk);
    end
    check("abort/no_done", 32'(mis), 32'd0);
    check("abort/eng_writes", 32'(eng_log.size()), 32'd99);
    old = mdl;
    for (int a = 0; a < 99; a++) mdl[a] = old[a + COLS];
    mis = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== mdl[i]) mis++;
    check("abort/txbl_contents", 32'(mis), 32'd0);
    rst_n = 1'b1;
    run_cmd(2'b01, 8'h19, 10'h3A0, 40, 25, -1, -1, "fill_after_abort");

`ifdef TEXT_BLIT_IRQ_EN
    @(negedge cpu_clk);
    irq_clr = 1'b1;
    @(negedge cpu_clk);
    irq_clr = 1'b0;
    check("irq/cleared", 32'(irq), 32'd0);
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    @(negedge cpu_clk);
    cmd_valid = 1'b0;
    check("irq/rise_with_done", 32'(irq), 32'd1);
    irq_clr = 1'b1;
    @(negedge cpu_clk);
    check("irq/set_wins", 32'(irq), 32'd1);
    @(negedge cpu_clk);
    irq_clr = 1'b0;
    check("irq/clear", 32'(irq), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
